// File: rtl/pcie_status_pkg.sv
// pcie_status_pkg
// Shared definitions for the PCIe status/LED controller:
//   - link_state_e : link FSM state encodings (also the link_state output)
//   - DEF_CNT_WIDTH: default statistics counter width
//   - sat_inc      : saturating +1 for counters up to 32 bits wide
package pcie_status_pkg;

  typedef enum logic [1:0] {
    LINK_DOWN     = 2'b00,
    LINK_DEBOUNCE = 2'b01,
    LINK_UP       = 2'b10
  } link_state_e;

  localparam int DEF_CNT_WIDTH = 16;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    return (v >= max_v) ? v : v + 32'h1;
  endfunction

endpackage

// File: rtl/pcie_status_led_ctrl_pulse_hold.sv
// pulse_hold
// Retriggerable event stretcher. Any cycle with evt high loads the hold
// counter with N; each tick then decrements it while nonzero. out is high
// while the counter is nonzero, registered, so it rises the cycle after evt.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   tick       : one-cycle prescaler pulse
//   evt        : event strobe
//   out        : stretched indicator
module pulse_hold #(
  parameter int N = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic evt,
  output logic out
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;

  always_comb begin
    cnt_d = cnt_q;
    // A new event wins over a coincident tick so the full hold restarts.
    if (evt)                      cnt_d = CW'(N);
    else if (tick && cnt_q != '0) cnt_d = cnt_q - CW'(1);
    out_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/pcie_status_led_ctrl.sv
// pcie_status_led_ctrl
// Status/indicator controller for the PCIe endpoint (user clock domain).
// Ports:
//   clk, rst_n          : PCIe user clock, async active-low reset
//   link_up             : raw link-up from the hard block
//   error_cor/uncor     : error strobes, counted per cycle high
//   ch_activity         : per-channel transfer strobes
//   clear_stats         : sync clear of counters and sticky uncorrectable flag
//   led_link            : off (DOWN) / blink (DEBOUNCE) / on (UP)
//   led_err             : sticky uncorrectable OR stretched correctable
//   led_act             : stretched per-channel activity
//   link_state          : 00 DOWN, 01 DEBOUNCE, 10 UP
//   link_drop_count, err_cor_count, err_uncor_count : saturating counters
module pcie_status_led_ctrl
  import pcie_status_pkg::*;
#(
  parameter int CHANNEL_COUNT       = 4,
  parameter int PRESCALE            = 250000,
  parameter int LINK_DEBOUNCE_TICKS = 10,
  parameter int BLINK_TICKS         = 100,
  parameter int ERR_HOLD_TICKS      = 500,
  parameter int STRETCH_TICKS       = 50,
  parameter int CNT_WIDTH           = DEF_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     link_up,
  input  logic                     error_cor,
  input  logic                     error_uncor,
  input  logic [CHANNEL_COUNT-1:0] ch_activity,
  input  logic                     clear_stats,
  output logic                     led_link,
  output logic                     led_err,
  output logic [CHANNEL_COUNT-1:0] led_act,
  output logic [1:0]               link_state,
  output logic [CNT_WIDTH-1:0]     link_drop_count,
  output logic [CNT_WIDTH-1:0]     err_cor_count,
  output logic [CNT_WIDTH-1:0]     err_uncor_count
);

  localparam int PW = $clog2(PRESCALE);
  localparam int DW = $clog2(LINK_DEBOUNCE_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  // ---------------- prescaler (free-running) ----------------
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  always_comb begin
    tick    = (presc_q == PW'(PRESCALE - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // ---------------- link FSM ----------------
  link_state_e   state_q, state_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          led_link_q, led_link_d;
  logic          drop_evt;

  always_comb begin
    state_d    = state_q;
    deb_d      = deb_q;
    blink_d    = blink_q;
    led_link_d = led_link_q;
    drop_evt   = 1'b0;
    case (state_q)
      LINK_DOWN: begin
        led_link_d = 1'b0;
        if (link_up) begin
          state_d    = LINK_DEBOUNCE;
          deb_d      = DW'(LINK_DEBOUNCE_TICKS);
          blink_d    = BW'(BLINK_TICKS);
          led_link_d = 1'b1;
        end
      end
      LINK_DEBOUNCE: begin
        if (!link_up) begin
          state_d    = LINK_DOWN;
          led_link_d = 1'b0;
        end else if (tick) begin
          if (deb_q == DW'(1)) begin
            state_d    = LINK_UP;
            deb_d      = '0;
            led_link_d = 1'b1;
          end else begin
            deb_d = deb_q - DW'(1);
            if (blink_q == BW'(1)) begin
              blink_d    = BW'(BLINK_TICKS);
              led_link_d = ~led_link_q;
            end else begin
              blink_d = blink_q - BW'(1);
            end
          end
        end
      end
      LINK_UP: begin
        led_link_d = 1'b1;
        if (!link_up) begin
          state_d    = LINK_DOWN;
          led_link_d = 1'b0;
          drop_evt   = 1'b1;
        end
      end
      default: begin
        // 2'b11 is never entered; fall back to a clean DOWN.
        state_d    = LINK_DOWN;
        led_link_d = 1'b0;
      end
    endcase
  end

  // ---------------- counters / sticky error ----------------
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0] cor_cnt_q, cor_cnt_d;
  logic [CNT_WIDTH-1:0] unc_cnt_q, unc_cnt_d;
  logic                 sticky_q, sticky_d;

  always_comb begin
    // Clear first, then increment: a coincident event leaves the count at 1.
    drop_cnt_d = clear_stats ? '0 : drop_cnt_q;
    cor_cnt_d  = clear_stats ? '0 : cor_cnt_q;
    unc_cnt_d  = clear_stats ? '0 : unc_cnt_q;
    if (drop_evt)    drop_cnt_d = CNT_WIDTH'(sat_inc(32'(drop_cnt_d), CNT_WIDTH));
    if (error_cor)   cor_cnt_d  = CNT_WIDTH'(sat_inc(32'(cor_cnt_d), CNT_WIDTH));
    if (error_uncor) unc_cnt_d  = CNT_WIDTH'(sat_inc(32'(unc_cnt_d), CNT_WIDTH));
    sticky_d = error_uncor | (sticky_q & ~clear_stats);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      state_q    <= LINK_DOWN;
      deb_q      <= '0;
      blink_q    <= '0;
      led_link_q <= 1'b0;
      drop_cnt_q <= '0;
      cor_cnt_q  <= '0;
      unc_cnt_q  <= '0;
      sticky_q   <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      state_q    <= state_d;
      deb_q      <= deb_d;
      blink_q    <= blink_d;
      led_link_q <= led_link_d;
      drop_cnt_q <= drop_cnt_d;
      cor_cnt_q  <= cor_cnt_d;
      unc_cnt_q  <= unc_cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  // ---------------- LED stretchers ----------------
  logic cor_hold;

  for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : g_act
    pulse_hold #(.N(STRETCH_TICKS)) u_hold (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick),
      .evt  (ch_activity[i]),
      .out  (led_act[i])
    );
  end

  pulse_hold #(.N(ERR_HOLD_TICKS)) u_cor_hold (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick),
    .evt  (error_cor),
    .out  (cor_hold)
  );

  // Both terms come straight from flops.
  assign led_err         = sticky_q | cor_hold;
  assign led_link        = led_link_q;
  assign link_state      = state_q;
  assign link_drop_count = drop_cnt_q;
  assign err_cor_count   = cor_cnt_q;
  assign err_uncor_count = unc_cnt_q;

endmodule

// File: tb/tb_pcie_status_led_ctrl.sv
// Bench for pcie_status_led_ctrl: directed stimulus, a tick-arithmetic
// reference model compared every cycle, plus hand-computed literal checks.
module tb_pcie_status_led_ctrl;

  localparam int NCH  = 4;
  localparam int P    = 4;
  localparam int DEB  = 3;
  localparam int BLK  = 2;
  localparam int STR  = 3;
  localparam int ERRH = 5;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic link_up = 1'b0, error_cor = 1'b0, error_uncor = 1'b0, clear_stats = 1'b0;
  logic [NCH-1:0] ch_activity = '0;
  logic led_link, led_err;
  logic [NCH-1:0] led_act;
  logic [1:0] link_state;
  logic [CW-1:0] link_drop_count, err_cor_count, err_uncor_count;

  int checks = 0;
  int errors = 0;

  pcie_status_led_ctrl #(
    .CHANNEL_COUNT(NCH), .PRESCALE(P), .LINK_DEBOUNCE_TICKS(DEB),
    .BLINK_TICKS(BLK), .ERR_HOLD_TICKS(ERRH), .STRETCH_TICKS(STR), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .link_up(link_up), .error_cor(error_cor),
    .error_uncor(error_uncor), .ch_activity(ch_activity), .clear_stats(clear_stats),
    .led_link(led_link), .led_err(led_err), .led_act(led_act), .link_state(link_state),
    .link_drop_count(link_drop_count), .err_cor_count(err_cor_count),
    .err_uncor_count(err_uncor_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Cycle k after reset release has prescaler value k mod P; a tick happens
  // in every cycle with k mod P == P-1.
  int cyc = 0;
  int m_mode = 0;          // 0 down, 1 debounce, 2 up
  int m_ent = 0;           // cycle link_up was first seen in DOWN
  int m_last_act[NCH] = '{default: -1};
  int m_last_cor = -1;
  int m_sticky = 0;
  int m_drop = 0, m_cor = 0, m_unc = 0;

  function automatic int ticks(int a, int b);
    if (b < a) return 0;
    return (b + 1) / P - a / P;
  endfunction

  function automatic int bump(int c, bit clr, bit ev);
    int r;
    r = clr ? 0 : c;
    if (ev) r = (r + 1 > CMAX) ? CMAX : r + 1;
    return r;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      cyc = 0; m_mode = 0; m_ent = 0; m_last_cor = -1; m_sticky = 0;
      m_drop = 0; m_cor = 0; m_unc = 0;
      for (int i = 0; i < NCH; i++) m_last_act[i] = -1;
    end else begin
      for (int i = 0; i < NCH; i++) if (ch_activity[i]) m_last_act[i] = cyc;
      if (error_cor) m_last_cor = cyc;
      m_cor = bump(m_cor, clear_stats, error_cor);
      m_unc = bump(m_unc, clear_stats, error_uncor);
      if (error_uncor) m_sticky = 1;
      else if (clear_stats) m_sticky = 0;
      case (m_mode)
        0: if (link_up) begin m_mode = 1; m_ent = cyc; end
        1: if (!link_up) m_mode = 0;
           else if (ticks(m_ent + 1, cyc) >= DEB) m_mode = 2;
        default: if (!link_up) begin
          m_mode = 0;
          m_drop = bump(m_drop, clear_stats, 1'b1);
        end
      endcase
      if (m_mode != 0 || link_up) ; // nothing else to track
      if (clear_stats && !(m_mode == 0 && 0)) ; // drop clear handled below
      cyc = cyc + 1;
    end
  end

  // clear_stats also zeroes the drop count when no drop happens that cycle.
  initial forever begin
    @(posedge clk);
    #0;
    if (rst_n && clear_stats && m_drop != 0 && !(last_was_drop())) m_drop = 0;
  end

  // A drop was just recorded this edge only if the model went UP->DOWN.
  bit m_prev_up = 0;
  bit m_drop_now = 0;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin m_prev_up = 0; m_drop_now = 0; end
    else begin
      m_drop_now = m_prev_up && !link_up;
      m_prev_up = (m_mode == 2) || (m_prev_up && link_up);
    end
  end
  function automatic bit last_was_drop();
    return m_drop_now;
  endfunction

  task automatic cmp(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cmp_rng(string name, int act, int lo, int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d..%0d", name, $time, act, lo, hi);
    end
  endtask

  // Per-cycle comparison against the model.
  initial forever begin
    int k, e_led, e_err, e_act;
    @(negedge clk);
    if (rst_n) begin
      k = cyc - 1;
      case (m_mode)
        0: e_led = 0;
        1: e_led = ((ticks(m_ent + 1, k) / BLK) % 2 == 0) ? 1 : 0;
        default: e_led = 1;
      endcase
      e_err = (m_sticky != 0 || (m_last_cor >= 0 && ticks(m_last_cor + 1, k) < ERRH)) ? 1 : 0;
      e_act = 0;
      for (int i = 0; i < NCH; i++)
        if (m_last_act[i] >= 0 && ticks(m_last_act[i] + 1, k) < STR) e_act |= (1 << i);
      cmp("m_link_state", int'(link_state), (m_mode == 2) ? 2 : m_mode);
      cmp("m_led_link", int'(led_link), e_led);
      cmp("m_led_err", int'(led_err), e_err);
      cmp("m_led_act", int'(led_act), e_act);
      cmp("m_drop_cnt", int'(link_drop_count), m_drop);
      cmp("m_cor_cnt", int'(err_cor_count), m_cor);
      cmp("m_unc_cnt", int'(err_uncor_count), m_unc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc_wait(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic meas_deb(output int nd, output int nlow);
    nd = 0; nlow = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (link_state == 2'b10) break;
      if (link_state == 2'b01) begin
        nd++;
        if (!led_link) nlow++;
      end
    end
  endtask

  task automatic meas_high_act(input int ch, output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!led_act[ch]) break;
      n++;
    end
  endtask

  task automatic meas_high_err(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!led_err) break;
      n++;
    end
  endtask

  function automatic int all_out();
    return int'(|{led_link, led_err, led_act, link_state,
                  link_drop_count, err_cor_count, err_uncor_count});
  endfunction

  initial begin
    int nd, nlow, n;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_outputs_zero", all_out(), 0);
    rst_n = 1'b1;

    // 1: debounce to UP with blink
    link_up = 1'b1;
    meas_deb(nd, nlow);
    cmp_rng("debounce_len", nd, 9, 12);
    cmp("blink_low_cycles", nlow, 4);
    cmp("up_led_link", int'(led_link), 1);

    // 2: UP->DOWN drop, then an aborted debounce
    @(posedge clk); #1;
    link_up = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmp("drop_state", int'(link_state), 0);
    cmp("drop_count", int'(link_drop_count), 1);
    cmp("drop_led_link", int'(led_link), 0);
    @(posedge clk); #1;
    link_up = 1'b1;
    cyc_wait(4);
    cmp("abort_in_debounce", int'(link_state), 1);
    cyc_wait(4);
    link_up = 1'b0;
    cyc_wait(2);
    cmp("abort_state", int'(link_state), 0);
    cmp("abort_no_drop", int'(link_drop_count), 1);

    // 3: activity stretch and retrigger
    ch_activity = 4'b0100;
    @(negedge clk);
    cmp("act_latency", int'(led_act[2]), 0);
    @(posedge clk); #1;
    ch_activity = '0;
    meas_high_act(2, n);
    cmp_rng("act_hold", n, 9, 12);
    @(posedge clk); #1;
    ch_activity = 4'b0100;
    cyc_wait(1);
    ch_activity = '0;
    cyc_wait(5);
    ch_activity = 4'b0100;
    cyc_wait(1);
    ch_activity = '0;
    meas_high_act(2, n);
    cmp_rng("act_retrigger_hold", n, 9, 12);

    // 4: correctable saturation and hold, then sticky uncorrectable
    @(posedge clk); #1;
    error_cor = 1'b1;
    cyc_wait(20);
    error_cor = 1'b0;
    cmp("cor_saturate", int'(err_cor_count), 15);
    meas_high_err(n);
    cmp_rng("err_hold", n, 17, 20);
    @(posedge clk); #1;
    error_uncor = 1'b1;
    cyc_wait(1);
    error_uncor = 1'b0;
    cyc_wait(40);
    cmp("sticky_led_err", int'(led_err), 1);
    cmp("uncor_count", int'(err_uncor_count), 1);

    // 5: clear together with uncorrectable, then a lone clear
    clear_stats = 1'b1;
    error_uncor = 1'b1;
    cyc_wait(1);
    clear_stats = 1'b0;
    error_uncor = 1'b0;
    cmp("clr_ev_uncor_count", int'(err_uncor_count), 1);
    cmp("clr_ev_led_err", int'(led_err), 1);
    cmp("clr_cor_count", int'(err_cor_count), 0);
    cmp("clr_drop_count", int'(link_drop_count), 0);
    clear_stats = 1'b1;
    cyc_wait(1);
    clear_stats = 1'b0;
    cmp("clr_uncor_zero", int'(err_uncor_count), 0);
    cmp("clr_led_err_off", int'(led_err), 0);

    // 6: async reset mid-debounce with LEDs lit
    link_up = 1'b1;
    ch_activity = 4'b1111;
    error_uncor = 1'b1;
    cyc_wait(1);
    ch_activity = '0;
    error_uncor = 1'b0;
    cyc_wait(4);
    cmp("pre_reset_debounce", int'(link_state), 1);
    #2 rst_n = 1'b0;
    #1;
    cmp("async_reset_zero", all_out(), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    meas_deb(nd, nlow);
    cmp_rng("debounce_after_reset", nd, 9, 12);
    cmp("blink_low_after_reset", nlow, 4);
    cyc_wait(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got timeout expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
